// File: rtl/pid_deriv_filt_if.sv
// rtl/pid_deriv_filt_if.sv - sample, gain and result signals of the PID derivative stage
interface pid_deriv_filt_if #(
  parameter int N = 19
);
  logic                en_reg;
  logic                clr;
  logic signed [N-1:0] kd;
  logic                filt_en;
  logic signed [N-1:0] yk_act;
  logic signed [N-1:0] out_dk_reg;
  logic                out_valid;
  logic                sat_flag;

  modport master (
    output en_reg, clr, kd, filt_en, yk_act,
    input  out_dk_reg, out_valid, sat_flag
  );

  modport slave (
    input  en_reg, clr, kd, filt_en, yk_act,
    output out_dk_reg, out_valid, sat_flag
  );
endinterface

// File: rtl/pid_deriv_filt.sv
// rtl/pid_deriv_filt.sv - gained, saturated and optionally low-passed derivative d(k) = Kd*(y(k)-y(k-1))
module pid_deriv_filt #(
  parameter int N          = 19,
  parameter int FRAC       = 8,
  parameter int FILT_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  pid_deriv_filt_if.slave bus
);
  localparam logic signed [2*N:0] MAXV = (2*N+1)'(2**(N-1) - 1);
  localparam logic signed [2*N:0] MINV = (2*N+1)'(-(2**(N-1)));

  logic signed [N-1:0] yk_ant;
  logic                primed;
  logic signed [N:0]   d0;
  logic                v0;
  logic signed [N-1:0] m1;
  logic                s1;
  logic                v1;
  logic signed [N-1:0] f;
  logic                out_valid_q;
  logic                sat_flag_q;

  logic signed [N:0]   d_raw;
  logic signed [2*N:0] p;
  logic signed [2*N:0] m_full;
  logic signed [N-1:0] m_sat;
  logic                m_clip;
  logic signed [N:0]   f_diff;
  logic signed [N-1:0] f_step;
  logic signed [N-1:0] f_next;

  always_comb begin
    d_raw  = {bus.yk_act[N-1], bus.yk_act} - {yk_ant[N-1], yk_ant};
    p      = (2*N+1)'(bus.kd) * (2*N+1)'(d0);
    m_full = p >>> FRAC;
    m_clip = (m_full > MAXV) || (m_full < MINV);
    if (m_full > MAXV)
      m_sat = MAXV[N-1:0];
    else if (m_full < MINV)
      m_sat = MINV[N-1:0];
    else
      m_sat = m_full[N-1:0];
    // f + floor((m-f)/2^k) always lies between f and m, so N bits suffice
    f_diff = {m1[N-1], m1} - {f[N-1], f};
    f_step = N'(f_diff >>> FILT_SHIFT);
    f_next = bus.filt_en ? (f + f_step) : m1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yk_ant      <= '0;
      primed      <= 1'b0;
      d0          <= '0;
      v0          <= 1'b0;
      m1          <= '0;
      s1          <= 1'b0;
      v1          <= 1'b0;
      f           <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else if (bus.clr) begin
      yk_ant      <= '0;
      primed      <= 1'b0;
      d0          <= '0;
      v0          <= 1'b0;
      m1          <= '0;
      s1          <= 1'b0;
      v1          <= 1'b0;
      f           <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      v0 <= bus.en_reg;
      if (bus.en_reg) begin
        // the first sample after reset/clear has no predecessor
        d0     <= primed ? d_raw : '0;
        yk_ant <= bus.yk_act;
        primed <= 1'b1;
      end
      v1 <= v0;
      if (v0) begin
        m1 <= m_sat;
        s1 <= m_clip;
      end
      out_valid_q <= v1;
      if (v1) begin
        f          <= f_next;
        sat_flag_q <= s1;
      end
    end
  end

  assign bus.out_dk_reg = f;
  assign bus.out_valid  = out_valid_q;
  assign bus.sat_flag   = sat_flag_q;
endmodule

// File: tb/tb_pid_deriv_filt.sv
// tb/tb_pid_deriv_filt.sv - scoreboard bench for pid_deriv_filt with a behavioural reference model
module tb_pid_deriv_filt;
  localparam int N  = 19;
  localparam int FRAC = 8;
  localparam int FS = 2;
  localparam longint MAXV = (longint'(1) << (N-1)) - 1;
  localparam longint MINV = -(longint'(1) << (N-1));

  typedef struct {
    longint val;
    bit     sat;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  exp_t mon_e;

  longint m_prev;
  bit     m_primed;
  longint m_f;
  longint cur_kd;
  bit     cur_fe;

  pid_deriv_filt_if #(.N(N)) bus();

  pid_deriv_filt #(.N(N), .FRAC(FRAC), .FILT_SHIFT(FS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got out_valid=1 out_dk_reg=%0d, expected no output (t=%0t)",
                 $signed(bus.out_dk_reg), $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_dk_reg", longint'($signed(bus.out_dk_reg)), mon_e.val);
        chk("sat_flag", longint'(bus.sat_flag), longint'(mon_e.sat));
        chk("latency_cycle", longint'(cyc), longint'(mon_e.cyc));
      end
    end
  end

  task automatic model_clear();
    m_prev   = 0;
    m_primed = 0;
    m_f      = 0;
    sbq.delete();
  endtask

  // Drives one sample at a falling edge; en_reg is left high for back-to-back use
  task automatic issue(input longint y, input bit use_k = 0, input longint k_val = 0, input bit k_sat = 0);
    longint d;
    longint m;
    bit     s;
    exp_t   e;
    d = m_primed ? (y - m_prev) : 0;
    m_prev   = y;
    m_primed = 1;
    m = (cur_kd * d) >>> FRAC;
    s = (m > MAXV) || (m < MINV);
    if (m > MAXV) m = MAXV;
    else if (m < MINV) m = MINV;
    if (cur_fe) m_f = m_f + ((m - m_f) >>> FS);
    else m_f = m;
    e.val = use_k ? k_val : m_f;
    e.sat = use_k ? k_sat : s;
    e.cyc = cyc + 3;
    bus.en_reg = 1'b1;
    bus.yk_act = N'(y);
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.en_reg = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    bus.en_reg = 1'b0;
    t = 0;
    while (sbq.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    #1;
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic set_gain(input longint k, input bit fe);
    cur_kd      = k;
    cur_fe      = fe;
    bus.kd      = N'(k);
    bus.filt_en = fe;
  endtask

  task automatic do_clr(input bit with_en, input longint y);
    bus.clr    = 1'b1;
    bus.en_reg = with_en;
    bus.yk_act = N'(y);
    @(negedge clk);
    bus.clr    = 1'b0;
    bus.en_reg = 1'b0;
    model_clear();
  endtask

  task automatic check_hold(input int n, input longint hv);
    bus.en_reg = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("hold_out", longint'($signed(bus.out_dk_reg)), hv);
      chk("hold_valid", longint'(bus.out_valid), 0);
    end
  endtask

  function automatic longint rnd_full();
    return longint'($urandom_range(0, (1 << N) - 1)) - (longint'(1) << (N-1));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint kr;
    bus.en_reg  = 1'b0;
    bus.clr     = 1'b0;
    bus.kd      = '0;
    bus.filt_en = 1'b0;
    bus.yk_act  = '0;
    model_clear();
    set_gain(0, 0);

    @(negedge clk);
    chk("reset_out", longint'($signed(bus.out_dk_reg)), 0);
    chk("reset_valid", longint'(bus.out_valid), 0);
    chk("reset_sat", longint'(bus.sat_flag), 0);
    @(negedge clk);
    rst = 1'b0;

    // prime and step
    set_gain(256, 0);
    issue(0, 1, 0, 0);
    issue(100, 1, 100, 0);
    issue(100, 1, 0, 0);
    issue(-50, 1, -150, 0);
    drain();
    chk("step_final_out", longint'($signed(bus.out_dk_reg)), -150);

    // asynchronous reset with a token between E0 and E2
    issue(500);
    bus.en_reg = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("midrst_out", longint'($signed(bus.out_dk_reg)), 0);
    chk("midrst_valid", longint'(bus.out_valid), 0);
    chk("midrst_sat", longint'(bus.sat_flag), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // negative gain
    set_gain(-512, 0);
    issue(10, 1, 0, 0);
    issue(13, 1, -6, 0);
    drain();

    // saturation both ways
    do_clr(0, 0);
    set_gain(262143, 0);
    issue(0, 1, 0, 0);
    issue(1000, 1, 262143, 1);
    issue(1000, 1, 0, 0);
    issue(-1000, 1, -262144, 1);
    drain();
    chk("sat_hold", longint'(bus.sat_flag), 1);

    // low-pass on a ramp
    do_clr(0, 0);
    set_gain(65536, 1);
    issue(0, 1, 0, 0);
    issue(4, 1, 256, 0);
    issue(8, 1, 448, 0);
    issue(12, 1, 592, 0);
    issue(16, 1, 700, 0);
    drain();

    // clr beats a simultaneous sample, next sample re-primes
    set_gain(256, 0);
    issue(300);
    drain();
    do_clr(1, 5000);
    issue(777, 1, 0, 0);
    issue(800, 1, 23, 0);
    drain();

    // full-scale step: d = 2^N-1 without wrap
    do_clr(0, 0);
    set_gain(256, 0);
    issue(MINV, 1, 0, 0);
    issue(MAXV, 1, MAXV, 1);
    drain();

    // kd = 0
    set_gain(0, 1);
    issue(rnd_full());
    issue(rnd_full());
    drain();

    // randomized batches: back-to-back, then with gaps
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 1) == 1) do_clr(0, 0);
      if ($urandom_range(0, 2) == 0) kr = rnd_full();
      else kr = longint'($urandom_range(0, 1023)) - 512;
      set_gain(kr, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 8; i++) begin
        if (b >= 4 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) issue(rnd_full());
        else issue(m_prev + longint'($urandom_range(0, 200)) - 100);
      end
      drain();
      check_hold(5, m_f);
    end

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
